// File: rtl/ex_stage_mdu_pkg.sv
// Shared encodings and helpers for the iterative RV64 M-extension unit.
`timescale 1ns/1ps
package ex_stage_mdu_pkg;

    localparam int unsigned MduOpW = 3;

    typedef enum logic [MduOpW-1:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} mdu_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Magnitude at operating width; word results are zero-extended.
    function automatic logic [63:0] abs_w(input logic [63:0] x, input logic neg,
                                          input logic word);
        logic [63:0] t;
        t = neg ? (~x + 64'd1) : x;
        return word ? {32'b0, t[31:0]} : t;
    endfunction

endpackage

// File: rtl/ex_stage_mdu_iter.sv
// Radix-2 datapath: shift-add multiply, restoring divide (divide only with MDU_DIV_EN).
`timescale 1ns/1ps
module ex_stage_mdu_iter
    import ex_stage_mdu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         load_div,
    input  logic         load_word,
    input  logic [63:0]  mag_a,
    input  logic [63:0]  mag_b,
    output logic [127:0] acc
);

    logic [63:0]  a_q, a_d, sh_q, sh_d, hi_q, hi_d, lo_q, lo_d;
    logic [127:0] mul_nxt;

    // MSB-first: multiplier bits leave the top of sh_q.
    assign mul_nxt = ({hi_q, lo_q} << 1) + {64'b0, (sh_q[63] ? a_q : 64'b0)};

`ifdef MDU_DIV_EN
    logic        div_q, div_d;
    logic [64:0] part, diff;
    assign part = {hi_q, lo_q[63]};
    assign diff = part - {1'b0, a_q};
`endif

    always_comb begin
        a_d  = a_q;
        sh_d = sh_q;
        hi_d = hi_q;
        lo_d = lo_q;
`ifdef MDU_DIV_EN
        div_d = load ? load_div : div_q;
`endif
        if (load) begin
            hi_d = '0;
            lo_d = '0;
            a_d  = mag_a;
            sh_d = load_word ? {mag_b[31:0], 32'b0} : mag_b;
            if (load_div) begin
`ifdef MDU_DIV_EN
                a_d  = mag_b;
                sh_d = '0;
                lo_d = load_word ? {mag_a[31:0], 32'b0} : mag_a;
`else
                a_d  = '0;
                sh_d = '0;
`endif
            end
        end else if (step) begin
`ifdef MDU_DIV_EN
            if (div_q) begin
                hi_d = diff[64] ? part[63:0] : diff[63:0];
                lo_d = {lo_q[62:0], ~diff[64]};
            end else
`endif
            begin
                {hi_d, lo_d} = mul_nxt;
                sh_d         = {sh_q[62:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q  <= '0;
            sh_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
`ifdef MDU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            a_q  <= a_d;
            sh_q <= sh_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
`ifdef MDU_DIV_EN
            div_q <= div_d;
`endif
        end
    end

    assign acc = {hi_q, lo_q};

endmodule

// File: rtl/ex_stage_mdu.sv
// Multi-cycle RV64 M-extension unit: FSM, special cases, sign fix-up.
// Divide/remainder path is built only when MDU_DIV_EN is defined.
`timescale 1ns/1ps
module ex_stage_mdu
    import ex_stage_mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic        is_word_opt,
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    input  logic        flush,
    output logic        ready,
    output logic        stall_req,
    output logic        done,
    output logic [63:0] result
);

    mdu_state_e   state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    mdu_op_e      op_q, op_in;
    logic         word_q, sa_q, sb_q;
    logic [63:0]  result_q, fix_val, mag_a, mag_b;
    logic [127:0] acc, prod_fix;
    logic         accept, in_div, in_word, sa_signed, sb_signed, in_sa, in_sb, in_byp;

`ifdef MDU_DIV_EN
    logic [63:0] op1_q, dvd, q_fix, r_fix, div_res;
    logic        byp_q, div0_q, in_div0, in_ovf;
`endif

    assign ready     = (state_q == StIdle);
    assign done      = (state_q == StDone);
    assign stall_req = (state_q == StCalc) || (state_q == StFix) || (start && ready);
    assign accept    = start && ready && !flush;
    assign result    = result_q;

    always_comb begin
        op_in     = mdu_op_e'(mdu_op);
        in_div    = mdu_op[2];
        in_word   = is_word_opt && !(op_in inside {OpMulh, OpMulhsu, OpMulhu});
        sa_signed = op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem};
        sb_signed = op_in inside {OpMulh, OpDiv, OpRem};
        in_sa     = sa_signed && (in_word ? op1[31] : op1[63]);
        in_sb     = sb_signed && (in_word ? op2[31] : op2[63]);
        mag_a     = abs_w(op1, in_sa, in_word);
        mag_b     = abs_w(op2, in_sb, in_word);
`ifdef MDU_DIV_EN
        in_div0 = in_word ? (op2[31:0] == 32'd0) : (op2 == 64'd0);
        in_ovf  = sa_signed && (in_word ?
                  (op1[31:0] == 32'h8000_0000 && op2[31:0] == 32'hFFFF_FFFF) :
                  (op1 == 64'h8000_0000_0000_0000 && op2 == 64'hFFFF_FFFF_FFFF_FFFF));
        in_byp  = in_div && (in_div0 || in_ovf);
`else
        // Without a divider every divide/remainder resolves straight to zero.
        in_byp = in_div;
`endif
    end

    ex_stage_mdu_iter u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (state_q == StCalc),
        .load_div  (in_div),
        .load_word (in_word),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .acc       (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = in_byp ? StFix : StCalc;
                    cnt_d   = '0;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == (word_q ? 7'd31 : 7'd63)) state_d = StFix;
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? (~acc + 128'd1) : acc;
        fix_val  = '0;
`ifdef MDU_DIV_EN
        dvd     = word_q ? sext32(op1_q[31:0]) : op1_q;
        q_fix   = (sa_q ^ sb_q) ? (~acc[63:0] + 64'd1) : acc[63:0];
        r_fix   = sa_q ? (~acc[127:64] + 64'd1) : acc[127:64];
        div_res = '0;
`endif
        unique case (op_q)
            OpMul:                     fix_val = word_q ? sext32(acc[31:0]) : acc[63:0];
            OpMulh, OpMulhsu, OpMulhu: fix_val = prod_fix[127:64];
            default: begin
`ifdef MDU_DIV_EN
                if (byp_q) begin
                    if (div0_q) div_res = op_q[1] ? dvd : 64'hFFFF_FFFF_FFFF_FFFF;
                    else        div_res = op_q[1] ? 64'd0 : dvd;
                end else begin
                    div_res = op_q[1] ? r_fix : q_fix;
                end
                fix_val = word_q ? sext32(div_res[31:0]) : div_res;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= OpMul;
            word_q   <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
`ifdef MDU_DIV_EN
            op1_q  <= '0;
            byp_q  <= 1'b0;
            div0_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q   <= op_in;
                word_q <= in_word;
                sa_q   <= in_sa;
                sb_q   <= in_sb;
`ifdef MDU_DIV_EN
                op1_q  <= op1;
                byp_q  <= in_byp;
                div0_q <= in_div0;
`endif
            end
            if (state_q == StFix && !flush) result_q <= fix_val;
        end
    end

endmodule
